mipi_csi_frame_controller: RTL and testbench
============================================

// Module: mipi_csi_frame_controller
// PURPOSE
//  Frame-level sequencer for the CSI-2 receive path. Watches the lane-aligned 32-bit stream (same stream
//  that feeds mipi_csi_packet_decoder), decodes short packets FS/FE and long-packet headers, and gates
//  the decoder per frame (arm, skip N frames, single-shot/continuous capture). Produces frame/line
//  strobes, line and frame counters, and error flags for the downstream pixel path and USB control logic.
// PARAMETERS
//  LANES          4          bytes per beat; payload down-count step
//  LINE_CNT_W     16         width of line counter / line_count_o (saturating)
//  TIMEOUT_CYCLES 24'd1000000 clk_i cycles in ACTIVE without any header before frame is abandoned
// PORTS
//  clk_i            in   1          byte clock; all logic on posedge clk_i
//  reset_i          in   1          synchronous, active-high reset
//  data_valid_i     in   1          lane-aligned data valid (low between HS bursts)
//  data_i           in   32         lane-aligned data; byte0 = earliest lane byte
//  enable_i         in   1          capture armed (level)
//  single_shot_i    in   1          1 = capture one frame then stop; sampled at FS
//  skip_frames_i    in   4          frames to discard after arming before first capture
//  expected_wc_i    in   16         expected long-packet word count; 0 = no check
//  decoder_enable_o out  1          gates data_valid into mipi_csi_packet_decoder
//  frame_valid_o    out  1          high from FS+1 to FE+1 of a captured frame
//  line_valid_o     out  1          high while captured long-packet payload beats remain
//  frame_start_o    out  1          1-cycle pulse, captured FS
//  frame_end_o      out  1          1-cycle pulse, captured FE
//  line_count_o     out  LINE_CNT_W lines in last completed frame (latched at FE)
//  frame_count_o    out  16         captured frames since reset, wraps
//  err_wc_o / err_fs_o / err_timeout_o out 1 each  sticky; cleared by reset_i or enable_i rising
//  busy_o           out  1          state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, internal counters 0, prev-word register 0.
//  Header detect: prev word byte0 == 8'hB8 and payload_rem == 0 and data_valid_i -> header: DI=data_i[7:0],
//   WC={data_i[23:16],data_i[15:8]}. Long header (DI 0x2B/0x2C/0x2D) loads payload_rem=WC; while
//   payload_rem!=0 each valid beat subtracts LANES, saturating at 0; no header detect inside payload.
//  data_valid_i low: clears prev word and payload_rem (burst end); state unaffected.
//  FSM (registered, action visible cycle after header beat):
//   IDLE: all gates 0. enable_i=1 -> WAIT_FS, skip_cnt=0, sticky errors cleared.
//   WAIT_FS: FS (DI 0x00) -> skip_cnt<skip_frames_i ? SKIP : ACTIVE (frame_start_o pulse, line cnt=0,
//    latch single_shot). enable_i=0 -> IDLE.
//   SKIP: FE (DI 0x01) -> skip_cnt++ , WAIT_FS. enable_i=0 -> IDLE.
//   ACTIVE: decoder_enable_o=frame_valid_o=1. Long header: line cnt++ (saturate all-ones);
//    expected_wc_i!=0 and WC!=expected_wc_i -> err_wc_o. line_valid_o = payload_rem!=0.
//    FE -> frame_end_o pulse, line_count_o<=line cnt, frame_count_o++; next = (single_shot or !enable_i)
//    ? IDLE : WAIT_FS (skip not re-applied). FS while ACTIVE -> err_fs_o, frame_start_o pulse, line cnt=0,
//    stay ACTIVE. enable_i=0 mid-frame: finish to FE, then IDLE.
//    Watchdog counts cycles since last header; reaching TIMEOUT_CYCLES -> err_timeout_o, WAIT_FS,
//    no frame_end_o, frame_count_o unchanged.
//  FS/FE arrive in separate HS bursts, so decoder_enable_o never toggles inside a long packet.
//  Short packets other than FS/FE and long packets of other DI: ignored (no count, no error).
//  reset_i mid-frame: immediate return to reset values, gates drop the next edge.
// STRUCTURE
//  mipi_csi_pkg: SYNC_BYTE 8'hB8, DI codes (FS 00, FE 01, LS 02, LE 03, RAW10 2B, RAW12 2C, RAW14 2D),
//   FSM state enum {IDLE, WAIT_FS, SKIP, ACTIVE}.
//  Sub-module mipi_csi_header_detector: prev-word reg, payload_rem tracking; outputs hdr_valid, di, wc,
//   in_payload. FSM, counters, watchdog in this module.
// TESTING
//  enable=1, skip=0, continuous; FS, 3 RAW10 lines WC=16, FE -> frame_start/frame_end pulses,
//   line_count_o=3, frame_count_o=1, line_valid 4 beats per line.
//  skip=2: 3 frames -> frames 1-2 decoder_enable_o=0 throughout; frame 3 captured, frame_count_o=1.
//  single_shot=1: 2 frames -> only first captured, busy_o=0 after FE, second FS ignored.
//  expected_wc=16, one line WC=20 -> err_wc_o=1 sticky until enable_i re-rise; payload bytes B8 not
//   detected as header.
//  FS, FS, FE -> err_fs_o=1, line cnt restarted, line_count_o counts only after second FS.
//  FS then no headers for TIMEOUT_CYCLES (param 64 in bench) -> err_timeout_o, WAIT_FS; reset_i mid-
//   frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mipi_csi_pkg.sv
// Shared constants and types for the CSI-2 frame sequencer: sync byte,
// data-identifier codes, FSM states and the decoded-header record.
package mipi_csi_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  localparam logic [7:0] DI_FS    = 8'h00;
  localparam logic [7:0] DI_FE    = 8'h01;
  localparam logic [7:0] DI_LS    = 8'h02;
  localparam logic [7:0] DI_LE    = 8'h03;
  localparam logic [7:0] DI_RAW10 = 8'h2B;
  localparam logic [7:0] DI_RAW12 = 8'h2C;
  localparam logic [7:0] DI_RAW14 = 8'h2D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FS,
    ST_SKIP,
    ST_ACTIVE
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  di;
    logic [15:0] wc;
  } hdr_t;

  // Only these long packets carry pixel lines; other long DIs are ignored.
  function automatic logic is_long_di(input logic [7:0] di);
    return (di == DI_RAW10) || (di == DI_RAW12) || (di == DI_RAW14);
  endfunction

endpackage

// File: rtl/mipi_csi_header_detector.sv
// Finds packet headers in the lane-aligned stream (beat after a sync byte)
// and tracks remaining long-packet payload so payload bytes are never decoded.
module mipi_csi_header_detector
  import mipi_csi_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output hdr_t        hdr,
  output logic        in_payload
);

  localparam logic [15:0] STEP = 16'(LANES);

  logic [3:0][7:0] bytes;
  logic [7:0]      prev_byte0;
  logic [15:0]     payload_rem;
  logic            unused_ecc;

  assign bytes      = data_i;
  assign in_payload = (payload_rem != 16'd0);
  assign unused_ecc = ^bytes[3];

  always_comb begin
    hdr       = '0;
    hdr.valid = data_valid_i && (prev_byte0 == SYNC_BYTE) && !in_payload;
    hdr.di    = bytes[0];
    hdr.wc    = {bytes[2], bytes[1]};
  end

  // Payload beats never seed the sync register, so a B8 inside pixel data
  // cannot arm a false header on the following beat.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_byte0  <= 8'h00;
      payload_rem <= 16'd0;
    end else if (!data_valid_i) begin
      prev_byte0  <= 8'h00;
      payload_rem <= 16'd0;
    end else if (in_payload) begin
      prev_byte0  <= 8'h00;
      payload_rem <= (payload_rem > STEP) ? payload_rem - STEP : 16'd0;
    end else begin
      prev_byte0 <= bytes[0];
      if (hdr.valid && is_long_di(hdr.di))
        payload_rem <= hdr.wc;
    end
  end

endmodule

// File: rtl/mipi_csi_frame_controller.sv
// Frame-level sequencer: arms capture, skips frames, gates the packet decoder
// per frame and reports frame/line strobes, counters and sticky errors.
module mipi_csi_frame_controller
  import mipi_csi_pkg::*;
#(
  parameter int          LANES          = 4,
  parameter int          LINE_CNT_W     = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  data_valid_i,
  input  logic [31:0]           data_i,
  input  logic                  enable_i,
  input  logic                  single_shot_i,
  input  logic [3:0]            skip_frames_i,
  input  logic [15:0]           expected_wc_i,
  output logic                  decoder_enable_o,
  output logic                  frame_valid_o,
  output logic                  line_valid_o,
  output logic                  frame_start_o,
  output logic                  frame_end_o,
  output logic [LINE_CNT_W-1:0] line_count_o,
  output logic [15:0]           frame_count_o,
  output logic                  err_wc_o,
  output logic                  err_fs_o,
  output logic                  err_timeout_o,
  output logic                  busy_o
);

  hdr_t                  hdr;
  logic                  in_payload;
  state_t                state;
  logic                  enable_q;
  logic [3:0]            skip_cnt;
  logic                  single_lat;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic [23:0]           wd_cnt;
  logic                  en_rise, is_fs, is_fe, is_long;

  mipi_csi_header_detector #(.LANES(LANES)) u_hdr (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .hdr          (hdr),
    .in_payload   (in_payload)
  );

  assign en_rise = enable_i && !enable_q;
  assign is_fs   = hdr.valid && (hdr.di == DI_FS);
  assign is_fe   = hdr.valid && (hdr.di == DI_FE);
  assign is_long = hdr.valid && is_long_di(hdr.di);

  // Both terms are registered, so this tracks payload beats without glitches.
  assign line_valid_o = frame_valid_o && in_payload;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state            <= ST_IDLE;
      enable_q         <= 1'b0;
      skip_cnt         <= 4'd0;
      single_lat       <= 1'b0;
      line_cnt         <= '0;
      wd_cnt           <= 24'd0;
      decoder_enable_o <= 1'b0;
      frame_valid_o    <= 1'b0;
      frame_start_o    <= 1'b0;
      frame_end_o      <= 1'b0;
      line_count_o     <= '0;
      frame_count_o    <= 16'd0;
      err_wc_o         <= 1'b0;
      err_fs_o         <= 1'b0;
      err_timeout_o    <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      enable_q      <= enable_i;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      if (en_rise) begin
        err_wc_o      <= 1'b0;
        err_fs_o      <= 1'b0;
        err_timeout_o <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          // Edge-triggered arm: a finished single-shot stays idle while enable is held.
          if (en_rise) begin
            state    <= ST_WAIT_FS;
            skip_cnt <= 4'd0;
            busy_o   <= 1'b1;
          end
        end

        ST_WAIT_FS: begin
          if (!enable_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (is_fs) begin
            if (skip_cnt < skip_frames_i) begin
              state <= ST_SKIP;
            end else begin
              state            <= ST_ACTIVE;
              decoder_enable_o <= 1'b1;
              frame_valid_o    <= 1'b1;
              frame_start_o    <= 1'b1;
              line_cnt         <= '0;
              single_lat       <= single_shot_i;
              wd_cnt           <= 24'd0;
            end
          end
        end

        ST_SKIP: begin
          if (!enable_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (is_fe) begin
            skip_cnt <= skip_cnt + 4'd1;
            state    <= ST_WAIT_FS;
          end
        end

        ST_ACTIVE: begin
          if (is_fe) begin
            frame_end_o      <= 1'b1;
            line_count_o     <= line_cnt;
            frame_count_o    <= frame_count_o + 16'd1;
            decoder_enable_o <= 1'b0;
            frame_valid_o    <= 1'b0;
            if (single_lat || !enable_i) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= ST_WAIT_FS;
            end
          end else if (is_fs) begin
            err_fs_o      <= 1'b1;
            frame_start_o <= 1'b1;
            line_cnt      <= '0;
            wd_cnt        <= 24'd0;
          end else if (is_long) begin
            if (line_cnt != '1)
              line_cnt <= line_cnt + 1'b1;
            if ((expected_wc_i != 16'd0) && (hdr.wc != expected_wc_i))
              err_wc_o <= 1'b1;
            wd_cnt <= 24'd0;
          end else if (hdr.valid) begin
            wd_cnt <= 24'd0;
          end else if (wd_cnt == TIMEOUT_CYCLES - 24'd1) begin
            // Abandoned frame: no FE strobe and no frame count.
            err_timeout_o    <= 1'b1;
            decoder_enable_o <= 1'b0;
            frame_valid_o    <= 1'b0;
            state            <= ST_WAIT_FS;
            wd_cnt           <= 24'd0;
          end else begin
            wd_cnt <= wd_cnt + 24'd1;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_csi_frame_controller.sv
// Directed bench: one table-driven captured frame, then hand sequences for
// skip, single-shot, word-count, double-FS, watchdog and mid-frame reset.
module tb_mipi_csi_frame_controller;

  logic        clk = 1'b0;
  logic        reset_i, data_valid_i, enable_i, single_shot_i;
  logic [31:0] data_i;
  logic [3:0]  skip_frames_i;
  logic [15:0] expected_wc_i;
  logic        decoder_enable_o, frame_valid_o, line_valid_o;
  logic        frame_start_o, frame_end_o, busy_o;
  logic        err_wc_o, err_fs_o, err_timeout_o;
  logic [15:0] line_count_o, frame_count_o;

  always #5 clk = ~clk;

  mipi_csi_frame_controller #(
    .LANES(4), .LINE_CNT_W(16), .TIMEOUT_CYCLES(24'd64)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .data_valid_i(data_valid_i), .data_i(data_i),
    .enable_i(enable_i), .single_shot_i(single_shot_i), .skip_frames_i(skip_frames_i),
    .expected_wc_i(expected_wc_i), .decoder_enable_o(decoder_enable_o),
    .frame_valid_o(frame_valid_o), .line_valid_o(line_valid_o),
    .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
    .line_count_o(line_count_o), .frame_count_o(frame_count_o),
    .err_wc_o(err_wc_o), .err_fs_o(err_fs_o), .err_timeout_o(err_timeout_o),
    .busy_o(busy_o)
  );

  localparam logic [31:0] SYNC  = 32'h0000_00B8;
  localparam logic [31:0] FS_W  = 32'h0000_0000;
  localparam logic [31:0] FE_W  = 32'h0000_0001;
  localparam logic [31:0] PAY_A = 32'h0000_00B8;
  localparam logic [31:0] PAY_B = 32'h0000_102B;
  localparam logic [31:0] PAY_L = 32'h1122_3344;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [5:0]  exp;  // {decoder_en, frame_valid, line_valid, frame_start, frame_end, busy}
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0, n_bad = 0;
  int   fs_cnt = 0, fe_cnt = 0, dec_cyc = 0;

  always @(negedge clk) begin
    if (frame_start_o)    fs_cnt++;
    if (frame_end_o)      fe_cnt++;
    if (decoder_enable_o) dec_cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [31:0] d, input logic [5:0] e);
    vec_t r;
    r.v = v; r.d = d; r.exp = e;
    tbl.push_back(r);
  endtask

  task automatic apply(input logic v, input logic [31:0] d);
    @(negedge clk);
    data_valid_i = v;
    data_i       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1; enable_i = 1'b0; data_valid_i = 1'b0; data_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic arm();
    @(negedge clk);
    enable_i = 1'b1;
  endtask

  task automatic send_short(input logic [31:0] w);
    apply(1'b1, SYNC);
    apply(1'b1, w);
    apply(1'b0, 32'h0);
  endtask

  // Payload alternates a sync byte with a fake RAW10 header to catch false detection.
  task automatic send_line(input logic [15:0] wc);
    int beats;
    beats = (int'(wc) + 3) / 4;
    apply(1'b1, SYNC);
    apply(1'b1, {8'h00, wc[15:8], wc[7:0], 8'h2B});
    for (int i = 0; i < beats; i++)
      apply(1'b1, (i == beats - 1) ? PAY_L : ((i % 2 == 0) ? PAY_A : PAY_B));
    apply(1'b0, 32'h0);
  endtask

  task automatic send_frame(input int lines, input logic [15:0] wc);
    send_short(FS_W);
    for (int i = 0; i < lines; i++) send_line(wc);
    send_short(FE_W);
  endtask

  initial begin
    int f0, d0;
    reset_i = 1'b1; enable_i = 1'b0; data_valid_i = 1'b0; data_i = 32'h0;
    single_shot_i = 1'b0; skip_frames_i = 4'd0; expected_wc_i = 16'd0;

    // Reset state
    do_reset();
    #1;
    chk("reset_flags", {decoder_enable_o, frame_valid_o, line_valid_o, frame_start_o,
                        frame_end_o, busy_o, err_wc_o, err_fs_o, err_timeout_o}, 9'h000);
    chk("reset_counts", {line_count_o, frame_count_o}, 32'h0);

    // Table-driven continuous capture: FS, 3 RAW10 lines of WC=16, FE
    add(1'b1, SYNC, 6'b000001);
    add(1'b1, FS_W, 6'b110101);
    add(1'b0, 32'h0, 6'b110001);
    for (int l = 0; l < 3; l++) begin
      add(1'b1, SYNC,         6'b110001);
      add(1'b1, 32'h0000102B, 6'b111001);
      add(1'b1, PAY_A,        6'b111001);
      add(1'b1, PAY_B,        6'b111001);
      add(1'b1, PAY_A,        6'b111001);
      add(1'b1, PAY_L,        6'b110001);
      add(1'b0, 32'h0,        6'b110001);
    end
    add(1'b1, SYNC,  6'b110001);
    add(1'b1, FE_W,  6'b000011);
    add(1'b0, 32'h0, 6'b000001);

    arm();
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].v, tbl[i].d);
      chk($sformatf("tbl[%0d]", i),
          {decoder_enable_o, frame_valid_o, line_valid_o, frame_start_o, frame_end_o, busy_o},
          tbl[i].exp);
    end
    chk("t1_line_count", line_count_o, 16'd3);
    chk("t1_frame_count", frame_count_o, 16'd1);
    chk("t1_errs", {err_wc_o, err_fs_o, err_timeout_o}, 3'b000);

    // Skip two frames, capture the third
    do_reset();
    skip_frames_i = 4'd2;
    arm();
    d0 = dec_cyc; f0 = fs_cnt;
    send_frame(1, 16'd16);
    send_frame(1, 16'd16);
    chk("skip_dec_off", dec_cyc - d0, 0);
    chk("skip_no_fs", fs_cnt - f0, 0);
    chk("skip_busy", busy_o, 1'b1);
    send_frame(1, 16'd16);
    chk("skip_fcount", frame_count_o, 16'd1);
    chk("skip_fs_once", fs_cnt - f0, 1);
    skip_frames_i = 4'd0;

    // Single shot: second frame must be ignored
    do_reset();
    single_shot_i = 1'b1;
    arm();
    f0 = fs_cnt;
    send_frame(2, 16'd16);
    chk("ss_busy_after", busy_o, 1'b0);
    chk("ss_fcount1", frame_count_o, 16'd1);
    chk("ss_lcount", line_count_o, 16'd2);
    d0 = dec_cyc;
    send_frame(2, 16'd16);
    chk("ss_fcount2", frame_count_o, 16'd1);
    chk("ss_no_fs2", fs_cnt - f0, 1);
    chk("ss_dec_off", dec_cyc - d0, 0);
    single_shot_i = 1'b0;

    // Word-count error is sticky until enable re-rises
    do_reset();
    expected_wc_i = 16'd16;
    arm();
    send_short(FS_W);
    send_line(16'd16);
    chk("wc_ok", err_wc_o, 1'b0);
    send_line(16'd20);
    chk("wc_bad", err_wc_o, 1'b1);
    send_short(FE_W);
    chk("wc_lcount", line_count_o, 16'd2);
    send_frame(1, 16'd16);
    chk("wc_sticky", err_wc_o, 1'b1);
    chk("wc_fcount", frame_count_o, 16'd2);
    @(negedge clk); enable_i = 1'b0;
    idle(2);
    chk("wc_idle_busy", busy_o, 1'b0);
    chk("wc_still", err_wc_o, 1'b1);
    arm();
    idle(1);
    chk("wc_cleared", err_wc_o, 1'b0);
    expected_wc_i = 16'd0;

    // FS, FS, FE: line count restarts at the second FS
    do_reset();
    arm();
    f0 = fs_cnt;
    send_short(FS_W);
    send_line(16'd16);
    send_line(16'd16);
    chk("dfs_no_err", err_fs_o, 1'b0);
    send_short(FS_W);
    chk("dfs_err", err_fs_o, 1'b1);
    chk("dfs_fv", frame_valid_o, 1'b1);
    send_line(16'd16);
    send_short(FE_W);
    chk("dfs_lcount", line_count_o, 16'd1);
    chk("dfs_fs_pulses", fs_cnt - f0, 2);
    chk("dfs_fcount", frame_count_o, 16'd1);

    // Watchdog: 64 cycles without header abandons the frame
    do_reset();
    arm();
    f0 = fe_cnt;
    apply(1'b1, SYNC);
    apply(1'b1, FS_W);
    idle(60);
    chk("to_not_yet", {err_timeout_o, frame_valid_o}, 2'b01);
    idle(10);
    chk("to_fired", {err_timeout_o, frame_valid_o, decoder_enable_o, busy_o}, 4'b1001);
    chk("to_fcount", frame_count_o, 16'd0);
    chk("to_no_fe", fe_cnt - f0, 0);

    // Recapture after timeout, then reset mid-frame
    send_short(FS_W);
    apply(1'b1, SYNC);
    apply(1'b1, 32'h0000102B);
    chk("rst_pre", {frame_valid_o, line_valid_o}, 2'b11);
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_flags", {decoder_enable_o, frame_valid_o, line_valid_o, frame_start_o,
                          frame_end_o, busy_o, err_wc_o, err_fs_o, err_timeout_o}, 9'h000);
    chk("rst_mid_counts", {line_count_o, frame_count_o}, 32'h0);
    @(negedge clk);
    reset_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
